// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - round-robin interrupt arbiter with claim/complete handshake
//
// Shares one core external-interrupt input among N_SRC level sources. Each
// source is synchronised, rising edges are latched as pending bits, and one
// enabled pending source is chosen by round-robin starting at rr_ptr.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   src_irq       raw level interrupt inputs (asynchronous to clk)
//   global_en     master enable for arbitration
//   en_mask       per-source enable (1 = may be granted)
//   claim         1-cycle pulse: handler claims the current interrupt
//   complete      1-cycle pulse: handler finished source complete_id
//   complete_id   ID being completed
//   irq_req       level request to the core (high only in REQ)
//   irq_1shot     1-cycle pulse on each irq_req rise
//   claim_id      ID granted at the last successful claim
//   claim_valid   1-cycle pulse the cycle after a successful claim
//   pending       latched pending bits
module irq_arbiter #(
  parameter int N_SRC       = 4,
  parameter int IDW         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             global_en,
  input  logic [N_SRC-1:0] en_mask,
  input  logic             claim,
  input  logic             complete,
  input  logic [IDW-1:0]   complete_id,
  output logic             irq_req,
  output logic             irq_1shot,
  output logic [IDW-1:0]   claim_id,
  output logic             claim_valid,
  output logic [N_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_d;
  logic [N_SRC-1:0] src_edge;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] clr_mask;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   next_ptr;
  logic             any_cand;
  logic             irq_req_dly;
  logic             do_grant;
  logic             do_claim;
  logic             do_complete;

  // Synchroniser chain plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_d <= '0;
    end else begin
      sync_q[0] <= src_irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign src_edge = sync_q[SYNC_STAGES-1] & ~sync_d;
  assign cand     = pending & en_mask;

  // Round-robin search: first candidate at rr_ptr, rr_ptr+1, ... modulo N_SRC.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_b;
    winner   = '0;
    any_cand = 1'b0;
    idx      = 0;
    idx_b    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx   = (int'(rr_ptr) + i) % N_SRC;
      idx_b = IDW'(idx);
      if (!any_cand && cand[idx_b]) begin
        winner   = idx_b;
        any_cand = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    do_grant    = 1'b0;
    do_claim    = 1'b0;
    do_complete = 1'b0;
    case (state)
      IDLE: begin
        if (global_en && any_cand) begin
          do_grant  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // A claim outranks a withdraw seen in the same cycle.
        if (claim) begin
          do_claim  = 1'b1;
          state_nxt = SERVICE;
        end else if (!global_en || !en_mask[grant_id]) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (complete && (complete_id == grant_id)) begin
          do_complete = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (do_claim) clr_mask[grant_id] = 1'b1;
  end

  assign next_ptr = (grant_id == IDW'(N_SRC - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      grant_id    <= '0;
      claim_id    <= '0;
      claim_valid <= 1'b0;
      rr_ptr      <= '0;
      irq_req_dly <= 1'b0;
    end else begin
      // OR-ing the edge after the clear keeps a new event arriving with its claim.
      pending     <= (pending & ~clr_mask) | src_edge;
      claim_valid <= do_claim;
      irq_req_dly <= irq_req;
      if (do_grant)    grant_id <= winner;
      if (do_claim)    claim_id <= grant_id;
      if (do_complete) rr_ptr   <= next_ptr;
    end
  end

  assign irq_req   = (state == REQ);
  assign irq_1shot = irq_req & ~irq_req_dly;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - directed testbench for irq_arbiter
module tb_irq_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] src_irq;
  logic       global_en;
  logic [3:0] en_mask;
  logic       claim;
  logic       complete;
  logic [1:0] complete_id;
  logic       irq_req;
  logic       irq_1shot;
  logic [1:0] claim_id;
  logic       claim_valid;
  logic [3:0] pending;

  int checks   = 0;
  int failures = 0;

  irq_arbiter #(.N_SRC(4), .IDW(2), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_irq     (src_irq),
    .global_en   (global_en),
    .en_mask     (en_mask),
    .claim       (claim),
    .complete    (complete),
    .complete_id (complete_id),
    .irq_req     (irq_req),
    .irq_1shot   (irq_1shot),
    .claim_id    (claim_id),
    .claim_valid (claim_valid),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    src_irq     = 4'b0000;
    global_en   = 1'b1;
    en_mask     = 4'hF;
    claim       = 1'b0;
    complete    = 1'b0;
    complete_id = 2'd0;
    step(2);
    rst_n = 1'b1;
    step(3);
  endtask

  // Waits (bounded) for a fresh irq_req rise; must see the 1-shot with it.
  task automatic wait_req(input string tag);
    int n = 0;
    while (!irq_req && n < 20) begin
      step(1);
      n++;
    end
    check({tag, "_req"}, 32'(irq_req), 32'd1);
    check({tag, "_1shot"}, 32'(irq_1shot), 32'd1);
  endtask

  task automatic claim_expect(input string tag, input logic [1:0] id);
    wait_req(tag);
    claim = 1'b1;
    step(1);
    claim = 1'b0;
    check({tag, "_cvalid"}, 32'(claim_valid), 32'd1);
    check({tag, "_cid"}, 32'(claim_id), 32'(id));
  endtask

  task automatic do_complete(input logic [1:0] id);
    complete    = 1'b1;
    complete_id = id;
    step(1);
    complete = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_1shot", 32'(irq_1shot), 32'd0);
    check("rst_cvalid", 32'(claim_valid), 32'd0);
    check("rst_cid", 32'(claim_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);

    // 1: latency of a single edge, then claim
    do_reset();
    src_irq = 4'b0100;
    step(1);
    step(1);
    check("t1_pend_e1", 32'(pending), 32'h0);
    step(1);
    check("t1_pend_e2", 32'(pending), 32'h4);
    check("t1_req_e2", 32'(irq_req), 32'd0);
    step(1);
    check("t1_req_e3", 32'(irq_req), 32'd1);
    check("t1_1shot_e3", 32'(irq_1shot), 32'd1);
    step(1);
    check("t1_1shot_e4", 32'(irq_1shot), 32'd0);
    check("t1_req_e4", 32'(irq_req), 32'd1);
    claim = 1'b1;
    step(1);
    claim = 1'b0;
    check("t1_cid", 32'(claim_id), 32'd2);
    check("t1_cvalid", 32'(claim_valid), 32'd1);
    check("t1_pend_clr", 32'(pending), 32'h0);
    check("t1_req_off", 32'(irq_req), 32'd0);
    step(1);
    check("t1_cvalid_pulse", 32'(claim_valid), 32'd0);

    // 2: round-robin order, src 0 re-fires while rr_ptr moves on
    do_reset();
    src_irq = 4'b1011;
    claim_expect("t2_a", 2'd0);
    src_irq[0] = 1'b0;
    step(3);
    src_irq[0] = 1'b1;
    step(3);
    check("t2_pend", 32'(pending), 32'hB);
    do_complete(2'd0);
    claim_expect("t2_b", 2'd1);
    do_complete(2'd1);
    claim_expect("t2_c", 2'd3);
    do_complete(2'd3);
    claim_expect("t2_d", 2'd0);
    do_complete(2'd0);

    // 3: mask withdraw and re-request
    do_reset();
    src_irq = 4'b0010;
    wait_req("t3_a");
    en_mask = 4'b1101;
    step(1);
    check("t3_withdraw", 32'(irq_req), 32'd0);
    check("t3_pend_kept", 32'(pending), 32'h2);
    en_mask = 4'hF;
    step(1);
    check("t3_rereq", 32'(irq_req), 32'd1);
    check("t3_re1shot", 32'(irq_1shot), 32'd1);
    claim = 1'b1;
    step(1);
    claim = 1'b0;
    check("t3_cid", 32'(claim_id), 32'd1);
    do_complete(2'd1);

    // 4: SERVICE ignores wrong complete and claims; rr_ptr wraps to 0
    do_reset();
    src_irq = 4'b1000;
    claim_expect("t4_a", 2'd3);
    src_irq = 4'b1101;
    step(4);
    check("t4_pend", 32'(pending), 32'h5);
    do_complete(2'd2);
    step(2);
    check("t4_hold", 32'(irq_req), 32'd0);
    claim = 1'b1;
    step(1);
    claim = 1'b0;
    check("t4_svc_cvalid", 32'(claim_valid), 32'd0);
    check("t4_svc_cid", 32'(claim_id), 32'd3);
    do_complete(2'd3);
    claim_expect("t4_b", 2'd0);
    do_complete(2'd0);
    claim_expect("t4_c", 2'd2);
    do_complete(2'd2);

    // 5: edge coincides with claim of the same source
    do_reset();
    src_irq = 4'b0001;
    wait_req("t5_a");
    src_irq = 4'b0000;
    step(4);
    src_irq = 4'b0001;
    step(2);
    claim = 1'b1;
    step(1);
    claim = 1'b0;
    check("t5_cvalid", 32'(claim_valid), 32'd1);
    check("t5_cid", 32'(claim_id), 32'd0);
    check("t5_pend_kept", 32'(pending), 32'h1);
    do_complete(2'd0);
    claim_expect("t5_b", 2'd0);
    do_complete(2'd0);

    // 6: reset in SERVICE drops everything, no replay
    do_reset();
    src_irq = 4'b0010;
    claim_expect("t6_a", 2'd1);
    rst_n = 1'b0;
    #1;
    check("t6_req", 32'(irq_req), 32'd0);
    check("t6_1shot", 32'(irq_1shot), 32'd0);
    check("t6_cvalid", 32'(claim_valid), 32'd0);
    check("t6_cid", 32'(claim_id), 32'd0);
    check("t6_pend", 32'(pending), 32'h0);
    src_irq = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(10);
    check("t6_noreplay_req", 32'(irq_req), 32'd0);
    check("t6_noreplay_pend", 32'(pending), 32'h0);
    src_irq = 4'b0010;
    claim_expect("t6_b", 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
